// File: rtl/usb4_deser_pkg.sv
// Shared defaults and FSM encoding for the two-lane deserializer.
package usb4_deser_pkg;

    localparam int unsigned SYMBOL_W_DEF = 8;
    localparam int unsigned CNT_W_DEF    = 16;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } deser_state_e;

endpackage

// File: rtl/lane_bit_collector.sv
// One lane: LSB-first shift register plus the last completed symbol.
module lane_bit_collector #(
    parameter int unsigned SYMBOL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                capture,
    input  logic                complete,
    input  logic                bit_in,
    output logic [SYMBOL_W-1:0] sym
);

    logic [SYMBOL_W-1:0] shift_q;
    logic [SYMBOL_W-1:0] shift_next_c;

    // New bits enter at the top so the first bit ends up in bit 0.
    assign shift_next_c = {bit_in, shift_q[SYMBOL_W-1:1]};

    // Partial-symbol shift register; realign drops whatever was collected.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
        end else if (clear) begin
            shift_q <= '0;
        end else if (capture) begin
            shift_q <= shift_next_c;
        end
    end

    // Completed symbol register; only updated on the last bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sym <= '0;
        end else if (!clear && capture && complete) begin
            sym <= shift_next_c;
        end
    end

endmodule

// File: rtl/lanes_deserializer.sv
// Two-lane serial-to-symbol deserializer with shared bit counter and symbol count.
module lanes_deserializer
    import usb4_deser_pkg::*;
#(
    parameter int unsigned SYMBOL_W = SYMBOL_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_deser,
    input  logic                lane_0_rx,
    input  logic                lane_1_rx,
    input  logic                descr_rst,
    output logic [SYMBOL_W-1:0] lane_0_sym,
    output logic [SYMBOL_W-1:0] lane_1_sym,
    output logic                sym_valid,
    output logic [CNT_W-1:0]    sym_cnt,
    output logic                aligned
);

    localparam int unsigned BIT_CNT_W = $clog2(SYMBOL_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SYMBOL_W - 1);

    deser_state_e         state_q;
    deser_state_e         state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic                 capture_c;
    logic                 complete_c;

    // Next state, shared bit counter and capture strobes; realign wins over enable.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        capture_c  = 1'b0;
        complete_c = 1'b0;

        if (descr_rst) begin
            bit_cnt_d = '0;
        end else if (enable_deser) begin
            capture_c = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
                complete_c = 1'b1;
                bit_cnt_d  = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_deser && !descr_rst) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (descr_rst) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and bit counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Registered status outputs: completion pulse, pair count, alignment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sym_valid <= 1'b0;
            sym_cnt   <= '0;
            aligned   <= 1'b0;
        end else begin
            sym_valid <= complete_c;
            aligned   <= (state_d == ST_COLLECT);
            if (descr_rst) begin
                sym_cnt <= '0;
            end else if (complete_c) begin
                sym_cnt <= sym_cnt + CNT_W'(1);
            end
        end
    end

    lane_bit_collector #(
        .SYMBOL_W (SYMBOL_W)
    ) u_lane_0 (
        .clk      (clk),
        .rst      (rst),
        .clear    (descr_rst),
        .capture  (capture_c),
        .complete (complete_c),
        .bit_in   (lane_0_rx),
        .sym      (lane_0_sym)
    );

    lane_bit_collector #(
        .SYMBOL_W (SYMBOL_W)
    ) u_lane_1 (
        .clk      (clk),
        .rst      (rst),
        .clear    (descr_rst),
        .capture  (capture_c),
        .complete (complete_c),
        .bit_in   (lane_1_rx),
        .sym      (lane_1_sym)
    );

endmodule

// File: tb/tb_lanes_deserializer.sv
// Directed bench: table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_lanes_deserializer;

    logic        clk;
    logic        rst;
    logic        enable_deser;
    logic        lane_0_rx;
    logic        lane_1_rx;
    logic        descr_rst;
    logic [7:0]  lane_0_sym;
    logic [7:0]  lane_1_sym;
    logic        sym_valid;
    logic [15:0] sym_cnt;
    logic        aligned;
    logic [7:0]  lane_0_sym_4;
    logic [7:0]  lane_1_sym_4;
    logic        sym_valid_4;
    logic [3:0]  sym_cnt_4;
    logic        aligned_4;

    int checks;
    int errors;

    lanes_deserializer dut (
        .clk          (clk),
        .rst          (rst),
        .enable_deser (enable_deser),
        .lane_0_rx    (lane_0_rx),
        .lane_1_rx    (lane_1_rx),
        .descr_rst    (descr_rst),
        .lane_0_sym   (lane_0_sym),
        .lane_1_sym   (lane_1_sym),
        .sym_valid    (sym_valid),
        .sym_cnt      (sym_cnt),
        .aligned      (aligned)
    );

    lanes_deserializer #(.SYMBOL_W(8), .CNT_W(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .enable_deser (enable_deser),
        .lane_0_rx    (lane_0_rx),
        .lane_1_rx    (lane_1_rx),
        .descr_rst    (descr_rst),
        .lane_0_sym   (lane_0_sym_4),
        .lane_1_sym   (lane_1_sym_4),
        .sym_valid    (sym_valid_4),
        .sym_cnt      (sym_cnt_4),
        .aligned      (aligned_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        en;
        logic        dr;
        logic        l0;
        logic        l1;
        logic        ev;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [15:0] ec;
        logic        ea;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic en, input logic dr,
                                input logic l0, input logic l1, input logic ev,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [15:0] ec, input logic ea);
        vec_t v;
        v.r = r; v.en = en; v.dr = dr; v.l0 = l0; v.l1 = l1;
        v.ev = ev; v.e0 = e0; v.e1 = e1; v.ec = ec; v.ea = ea;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just past the rising edge.
    task automatic step(input logic r, input logic en, input logic dr,
                        input logic l0, input logic l1);
        rst          = r;
        enable_deser = en;
        descr_rst    = dr;
        lane_0_rx    = l0;
        lane_1_rx    = l1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] p0, p1, q0, q1, a0, a1, b0, b1;
        int         pulses;
        int         pulse_at[$];
        logic [7:0] got0[$];
        logic [7:0] got1[$];

        checks = 0;
        errors = 0;
        rst = 1'b0; enable_deser = 1'b0; descr_rst = 1'b0;
        lane_0_rx = 1'b0; lane_1_rx = 1'b0;

        p0 = 8'h4D; p1 = 8'h1E;
        q0 = 8'hA5; q1 = 8'h3C;

        // Reset dominates, then realign while idle.
        add(0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 16'd0, 0);
        add(0, 1, 0, 1, 1, 0, 8'h00, 8'h00, 16'd0, 0);
        add(1, 1, 1, 1, 1, 0, 8'h00, 8'h00, 16'd0, 0);
        // First symbol pair 4D / 1E.
        for (int i = 0; i < 8; i++) begin
            if (i < 7) add(1, 1, 0, p0[i], p1[i], 0, 8'h00, 8'h00, 16'd0, 1);
            else       add(1, 1, 0, p0[i], p1[i], 1, 8'h4D, 8'h1E, 16'd1, 1);
        end
        add(1, 0, 0, 0, 0, 0, 8'h4D, 8'h1E, 16'd1, 1);
        // Realign on the 8th bit discards the symbol.
        for (int i = 0; i < 7; i++) add(1, 1, 0, 1, 0, 0, 8'h4D, 8'h1E, 16'd1, 1);
        add(1, 1, 1, 1, 0, 0, 8'h4D, 8'h1E, 16'd0, 0);
        add(1, 0, 0, 1, 1, 0, 8'h4D, 8'h1E, 16'd0, 0);
        // Next full symbol is clean.
        for (int i = 0; i < 8; i++) begin
            if (i < 7) add(1, 1, 0, q0[i], q1[i], 0, 8'h4D, 8'h1E, 16'd0, 1);
            else       add(1, 1, 0, q0[i], q1[i], 1, 8'hA5, 8'h3C, 16'd1, 1);
        end
        add(1, 0, 1, 0, 0, 0, 8'hA5, 8'h3C, 16'd0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].en, vecs[i].dr, vecs[i].l0, vecs[i].l1);
            chk($sformatf("vec%0d_valid", i), 32'(sym_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_sym0", i), 32'(lane_0_sym), 32'(vecs[i].e0));
            chk($sformatf("vec%0d_sym1", i), 32'(lane_1_sym), 32'(vecs[i].e1));
            chk($sformatf("vec%0d_cnt", i), 32'(sym_cnt), 32'(vecs[i].ec));
            chk($sformatf("vec%0d_aligned", i), 32'(aligned), 32'(vecs[i].ea));
        end

        // Gap of 3 disabled cycles after bit 4.
        step(1, 0, 1, 0, 0);
        pulses = 0;
        pulse_at.delete(); got0.delete(); got1.delete();
        for (int i = 0; i < 13; i++) begin
            if (i < 4)                 step(1, 1, 0, p0[i], p1[i]);
            else if (i < 7)            step(1, 0, 0, 1, 1);
            else if (i < 11)           step(1, 1, 0, p0[i-3], p1[i-3]);
            else                       step(1, 0, 0, 0, 0);
            if (sym_valid) begin
                pulses++;
                pulse_at.push_back(i);
                got0.push_back(lane_0_sym);
                got1.push_back(lane_1_sym);
            end
        end
        chk("gap_pulses", 32'(pulses), 32'd1);
        if (pulses == 1) begin
            chk("gap_pulse_cycle", 32'(pulse_at[0]), 32'd10);
            chk("gap_sym0", 32'(got0[0]), 32'h4D);
            chk("gap_sym1", 32'(got1[0]), 32'h1E);
        end
        chk("gap_cnt", 32'(sym_cnt), 32'd1);

        // Back-to-back symbols, no bubble.
        a0 = 8'hA5; a1 = 8'h5A; b0 = 8'h3C; b1 = 8'hC3;
        step(1, 0, 1, 0, 0);
        pulses = 0;
        pulse_at.delete(); got0.delete(); got1.delete();
        for (int i = 0; i < 18; i++) begin
            if (i < 8)       step(1, 1, 0, a0[i], a1[i]);
            else if (i < 16) step(1, 1, 0, b0[i-8], b1[i-8]);
            else             step(1, 0, 0, 0, 0);
            if (sym_valid) begin
                pulses++;
                pulse_at.push_back(i);
                got0.push_back(lane_0_sym);
                got1.push_back(lane_1_sym);
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);
        if (pulses == 2) begin
            chk("b2b_spacing", 32'(pulse_at[1] - pulse_at[0]), 32'd8);
            chk("b2b_first_cycle", 32'(pulse_at[0]), 32'd7);
            chk("b2b_sym0_a", 32'(got0[0]), 32'hA5);
            chk("b2b_sym1_a", 32'(got1[0]), 32'h5A);
            chk("b2b_sym0_b", 32'(got0[1]), 32'h3C);
            chk("b2b_sym1_b", 32'(got1[1]), 32'hC3);
        end
        chk("b2b_cnt", 32'(sym_cnt), 32'd2);

        // Reset mid-symbol, then a clean all-ones symbol.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        chk("rst_mid_sym0", 32'(lane_0_sym), 32'h00);
        chk("rst_mid_sym1", 32'(lane_1_sym), 32'h00);
        chk("rst_mid_cnt", 32'(sym_cnt), 32'd0);
        chk("rst_mid_aligned", 32'(aligned), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 1, 1);
            chk($sformatf("rst_ff_valid%0d", i), 32'(sym_valid), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("rst_ff_sym0", 32'(lane_0_sym), 32'hFF);
        chk("rst_ff_sym1", 32'(lane_1_sym), 32'hFF);
        chk("rst_ff_cnt", 32'(sym_cnt), 32'd1);

        // 4-bit pair counter wraps 15 -> 0 -> 1.
        step(1, 0, 1, 0, 0);
        chk("wrap_start_cnt4", 32'(sym_cnt_4), 32'd0);
        for (int s = 0; s < 17; s++) begin
            for (int b = 0; b < 8; b++) begin
                step(1, 1, 0, b[0], s[0]);
                if (b == 7) begin
                    chk($sformatf("wrap_valid%0d", s), 32'(sym_valid_4), 32'd1);
                    chk($sformatf("wrap_cnt4_%0d", s), 32'(sym_cnt_4), 32'((s + 1) % 16));
                    chk($sformatf("wrap_cnt16_%0d", s), 32'(sym_cnt), 32'(s + 1));
                end
            end
        end
        chk("wrap_sym0", 32'(lane_0_sym_4), 32'hAA);
        chk("wrap_sym1", 32'(lane_1_sym_4), 32'h00);
        step(1, 0, 0, 0, 0);
        chk("wrap_valid_drop", 32'(sym_valid_4), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
